// File: rtl/gm_decode_queue.sv
// gm_decode_queue
// ---------------
// Decode-and-buffer stage between fetch and issue. Each accepted instruction
// word is classified from its top four bits (opcode). The classification and
// the original word are stored together as one FIFO entry. Entries are
// presented to issue in order.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  fetch handshake; in_instr is the raw word
//   flush           drop every buffered entry (takes effect next cycle)
//   out_valid/ready issue handshake
//   out_is_bool     bit load/store from I/O (opcodes 3 and 4)
//   out_ifunc       NOP=0, ADD=1, SUB=2, BOOL=3, ILL=7
//   out_sub_bool    sub-class bool flag
//   out_illegal     opcode not recognised (5..15)
//   out_instr       original word carried with its decode
//   count           current occupancy, 0..DEPTH
// All out_* data fields read as zero whenever out_valid is low.

module gm_decode_queue #(
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_is_bool,
    output logic [2:0]         out_ifunc,
    output logic               out_sub_bool,
    output logic               out_illegal,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    // Entry layout: {instr, isBool, ifunc[2:0], subBool, illegal}
    localparam int ENTRY_W = INSTR_W + 6;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] IFUNC_NOP  = 3'd0;
    localparam logic [2:0] IFUNC_ADD  = 3'd1;
    localparam logic [2:0] IFUNC_SUB  = 3'd2;
    localparam logic [2:0] IFUNC_BOOL = 3'd3;
    localparam logic [2:0] IFUNC_ILL  = 3'd7;

    // Opcode classification; every field starts at zero so no output can be X.
    function automatic logic [5:0] decodeOp(input logic [3:0] op);
        logic       isBool;
        logic [2:0] ifunc;
        logic       subBool;
        logic       illegal;
        isBool  = 1'b0;
        ifunc   = IFUNC_NOP;
        subBool = 1'b0;
        illegal = 1'b0;
        case (op)
            4'd0: ifunc = IFUNC_NOP;
            4'd1: ifunc = IFUNC_ADD;
            4'd2: ifunc = IFUNC_SUB;
            4'd3, 4'd4: begin
                ifunc   = IFUNC_BOOL;
                isBool  = 1'b1;
                subBool = 1'b1;
            end
            default: begin
                ifunc   = IFUNC_ILL;
                illegal = 1'b1;
            end
        endcase
        return {isBool, ifunc, subBool, illegal};
    endfunction

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] rdEntry;

    // A full queue still accepts when issue drains an entry in the same
    // cycle. in_ready is forced high while reset is held.
    assign in_ready  = rst | (count != FULL_CNT) | out_ready;
    assign out_valid = (count != '0);

    // Flush and reset swallow any handshake in their cycle.
    assign push = in_valid & in_ready & ~flush & ~rst;
    assign pop  = out_valid & out_ready & ~flush & ~rst;

    // ---- stage boundary: decode registered into FIFO storage ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= {in_instr, decodeOp(in_instr[INSTR_W-1 -: 4])};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ---- stage boundary: FIFO read, gated to zero when empty ----
    assign rdEntry = out_valid ? mem[rdPtr] : '0;

    assign out_instr    = rdEntry[ENTRY_W-1:6];
    assign out_is_bool  = rdEntry[5];
    assign out_ifunc    = rdEntry[4:2];
    assign out_sub_bool = rdEntry[1];
    assign out_illegal  = rdEntry[0];

endmodule

// File: tb/tb_gm_decode_queue.sv
module tb_gm_decode_queue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default instance (INSTR_W=16, DEPTH=4)
    logic        rst, in_valid, flush, out_ready;
    logic [15:0] in_instr;
    logic        in_ready, out_valid, out_is_bool, out_sub_bool, out_illegal;
    logic [2:0]  out_ifunc;
    logic [15:0] out_instr;
    logic [2:0]  count;

    // wide instance (INSTR_W=32, DEPTH=8)
    logic        rst8, in_valid8, flush8, out_ready8;
    logic [31:0] in_instr8;
    logic        in_ready8, out_valid8, out_is_bool8, out_sub_bool8, out_illegal8;
    logic [2:0]  out_ifunc8;
    logic [31:0] out_instr8;
    logic [3:0]  count8;

    gm_decode_queue #(.INSTR_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_is_bool(out_is_bool), .out_ifunc(out_ifunc),
        .out_sub_bool(out_sub_bool), .out_illegal(out_illegal),
        .out_instr(out_instr), .count(count)
    );

    gm_decode_queue #(.INSTR_W(32), .DEPTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_instr(in_instr8),
        .in_ready(in_ready8), .flush(flush8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_is_bool(out_is_bool8), .out_ifunc(out_ifunc8),
        .out_sub_bool(out_sub_bool8), .out_illegal(out_illegal8),
        .out_instr(out_instr8), .count(count8)
    );

    int nChecks = 0;
    int nPass   = 0;
    bit started = 1'b0;
    logic [15:0] sbq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Hand-written opcode table: {isBool, ifunc, subBool, illegal}
    function automatic logic [5:0] expDec(input logic [3:0] op);
        case (op)
            4'd0:    return 6'b0_000_0_0;
            4'd1:    return 6'b0_001_0_0;
            4'd2:    return 6'b0_010_0_0;
            4'd3:    return 6'b1_011_1_0;
            4'd4:    return 6'b1_011_1_0;
            default: return 6'b0_111_0_1;
        endcase
    endfunction

    // Monitor: compares the presented entry with the scoreboard head.
    always @(negedge clk) begin
        logic [15:0] w;
        if (started && !rst) begin
            chk("count_vs_model", 64'(count), 64'(sbq.size()));
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    w = sbq[0];
                    chk("entry", {out_instr, out_is_bool, out_ifunc, out_sub_bool, out_illegal},
                        {w, expDec(w[15:12])});
                    if (out_ready && !flush) void'(sbq.pop_front());
                end
            end else begin
                chk("idle_zero", {out_instr, out_is_bool, out_ifunc, out_sub_bool, out_illegal}, 64'd0);
            end
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [15:0] w, input logic f,
                       input logic r, input logic ordy, output logic acc);
        in_valid  = v;
        in_instr  = w;
        flush     = f;
        rst       = r;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready && !f && !r;
        @(posedge clk);
        if (r || f) sbq.delete();
        else if (acc) sbq.push_back(w);
        #1;
    endtask

    logic        a;
    logic [15:0] w;
    logic [2:0]  expIf [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd7};
    logic [3:0]  ops   [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9};

    initial begin
        rst8 = 1'b1; in_valid8 = 1'b0; in_instr8 = '0; flush8 = 1'b0; out_ready8 = 1'b0;
        @(posedge clk); #1;

        // reset
        cyc(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, a);
        chk("rst_in_ready_held", 64'(in_ready), 64'd1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, a);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data", {out_instr, out_is_bool, out_ifunc, out_sub_bool, out_illegal}, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        started = 1'b1;

        // opcode sweep, one output per cycle, each one cycle after its push
        for (int i = 0; i < 6; i++) begin
            w = {ops[i], 12'(12'h0A0 + i)};
            cyc(1'b1, w, 1'b0, 1'b0, 1'b1, a);
            chk("t1_accept", 64'(a), 64'd1);
            chk("t1_valid", 64'(out_valid), 64'd1);
            chk("t1_ifunc", 64'(out_ifunc), 64'(expIf[i]));
            chk("t1_instr", 64'(out_instr), 64'(w));
        end
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, a);

        // fill to DEPTH, then push and pop at once while full
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'h1200 + 16'(i), 1'b0, 1'b0, 1'b0, a);
        in_valid = 1'b1; in_instr = 16'h2BAD; out_ready = 1'b0; #1;
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cyc(1'b1, 16'h2BAD, 1'b0, 1'b0, 1'b0, a);
        chk("full_no_accept", 64'(a), 64'd0);
        cyc(1'b1, 16'h3A55, 1'b0, 1'b0, 1'b1, a);
        chk("full_pushpop_accept", 64'(a), 64'd1);
        chk("full_pushpop_count", 64'(count), 64'd4);
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, a);
        chk("t2_drained", 64'(count), 64'd0);

        // flush with a concurrent push and pop
        cyc(1'b1, 16'h2001, 1'b0, 1'b0, 1'b0, a);
        cyc(1'b1, 16'h4002, 1'b0, 1'b0, 1'b0, a);
        cyc(1'b1, 16'h1003, 1'b1, 1'b0, 1'b1, a);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_data", {out_instr, out_is_bool, out_ifunc, out_sub_bool, out_illegal}, 64'd0);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, a);
        chk("after_flush_count", 64'(count), 64'd1);
        chk("after_flush_ifunc", 64'(out_ifunc), 64'd1);
        chk("after_flush_instr", 64'(out_instr), 64'h1234);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, a);

        // stream 3*DEPTH words through random backpressure
        for (int i = 0; i < 12; i++) begin
            int tries;
            w = {4'(i), 12'(12'h300 + i)};
            tries = 0;
            do begin
                cyc(1'b1, w, 1'b0, 1'b0, 1'($urandom_range(0, 1)), a);
                tries++;
            end while (!a && tries < 50);
            if (!a) chk("stream_accept_timeout", 64'(a), 64'd1);
        end
        for (int i = 0; i < 20 && count != 0; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, a);
        chk("stream_drained", 64'(count), 64'd0);

        // reset mid-stream with 3 entries buffered
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h3100 + 16'(i), 1'b0, 1'b0, 1'b0, a);
        cyc(1'b1, 16'h1777, 1'b0, 1'b1, 1'b0, a);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", {out_instr, out_is_bool, out_ifunc, out_sub_bool, out_illegal}, 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);

        // wide instance: 32-bit words, depth 8
        rst8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid8 = 1'b1;
            in_instr8 = 32'h4ABC_DEF0 + 32'(i);
            cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, a);
            if (i == 0) begin
                chk("w32_valid", 64'(out_valid8), 64'd1);
                chk("w32_ifunc", 64'(out_ifunc8), 64'd3);
                chk("w32_is_bool", 64'(out_is_bool8), 64'd1);
                chk("w32_flags", {out_sub_bool8, out_illegal8}, 64'b10);
                chk("w32_instr", 64'(out_instr8), 64'h4ABC_DEF0);
            end
        end
        in_valid8 = 1'b1; #1;
        chk("w32_count", 64'(count8), 64'd8);
        chk("w32_in_ready", 64'(in_ready8), 64'd0);
        in_valid8 = 1'b0;

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
